// File: rtl/tlc_demand_scheduler.sv
// Demand-actuated two-approach traffic phase scheduler with min/max green,
// yellow and all-red clearance, plus latched pedestrian walk service.
module tlc_demand_scheduler #(
    parameter int TW        = 6,
    parameter int MIN_GREEN = 10,
    parameter int MAX_GREEN = 32,
    parameter int YELLOW    = 4,
    parameter int ALL_RED   = 4,
    parameter int WALK      = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          veh_req_a,
    input  logic          veh_req_b,
    input  logic          ped_req_a,
    input  logic          ped_req_b,
    output logic          a_red,
    output logic          a_yellow,
    output logic          a_green,
    output logic          b_red,
    output logic          b_yellow,
    output logic          b_green,
    output logic          walk_a,
    output logic          walk_b,
    output logic [2:0]    phase,
    output logic [TW-1:0] timer
);

    typedef enum logic [2:0] {
        A_GREEN  = 3'd0,
        A_YEL    = 3'd1,
        A_ALLRED = 3'd2,
        B_GREEN  = 3'd3,
        B_YEL    = 3'd4,
        B_ALLRED = 3'd5
    } phase_e;

    localparam logic [TW-1:0] MIN_LAST = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] MAX_LAST = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] YEL_LAST = TW'(YELLOW - 1);
    localparam logic [TW-1:0] AR_LAST  = TW'(ALL_RED - 1);
    localparam logic [TW-1:0] WALK_T   = TW'(WALK);

    phase_e        phase_r;
    phase_e        phase_nxt_s;
    logic [TW-1:0] timer_r;
    logic [TW-1:0] timer_nxt_s;
    logic          ped_latch_a_r;
    logic          ped_latch_b_r;
    logic          walk_act_a_r;
    logic          walk_act_b_r;
    logic          dem_a_s;
    logic          dem_b_s;
    logic          a_exit_s;
    logic          b_exit_s;
    logic          green_s;
    logic          enter_a_s;
    logic          enter_b_s;
    logic          leave_a_s;
    logic          leave_b_s;

    assign dem_a_s = veh_req_a | ped_latch_a_r;
    assign dem_b_s = veh_req_b | ped_latch_b_r;

    // Green ends early only when the own approach has gone quiet; at max green it yields regardless.
    assign a_exit_s = (timer_r >= MIN_LAST) & dem_b_s & (~veh_req_a | (timer_r == MAX_LAST));
    assign b_exit_s = (timer_r >= MIN_LAST) & dem_a_s & (~veh_req_b | (timer_r == MAX_LAST));

    assign green_s   = (phase_r == A_GREEN) | (phase_r == B_GREEN);
    assign enter_a_s = (phase_nxt_s == A_GREEN) & (phase_r != A_GREEN);
    assign enter_b_s = (phase_nxt_s == B_GREEN) & (phase_r != B_GREEN);
    assign leave_a_s = (phase_r == A_GREEN) & (phase_nxt_s != A_GREEN);
    assign leave_b_s = (phase_r == B_GREEN) & (phase_nxt_s != B_GREEN);

    // Next phase and phase timer; illegal codes fall back to the A all-red clearance.
    always_comb begin
        phase_nxt_s = phase_r;
        timer_nxt_s = timer_r;
        case (phase_r)
            A_GREEN:  if (a_exit_s) phase_nxt_s = A_YEL;    else phase_nxt_s = A_GREEN;
            A_YEL:    if (timer_r == YEL_LAST) phase_nxt_s = A_ALLRED; else phase_nxt_s = A_YEL;
            A_ALLRED: if (timer_r == AR_LAST)  phase_nxt_s = B_GREEN;  else phase_nxt_s = A_ALLRED;
            B_GREEN:  if (b_exit_s) phase_nxt_s = B_YEL;    else phase_nxt_s = B_GREEN;
            B_YEL:    if (timer_r == YEL_LAST) phase_nxt_s = B_ALLRED; else phase_nxt_s = B_YEL;
            B_ALLRED: if (timer_r == AR_LAST)  phase_nxt_s = A_GREEN;  else phase_nxt_s = B_ALLRED;
            default:  phase_nxt_s = A_ALLRED;
        endcase
        if (phase_nxt_s != phase_r) begin
            timer_nxt_s = {TW{1'b0}};
        end else if (green_s && (timer_r == MAX_LAST)) begin
            timer_nxt_s = timer_r;
        end else begin
            timer_nxt_s = timer_r + TW'(1);
        end
    end

    // Phase and timer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_r <= A_GREEN;
            timer_r <= {TW{1'b0}};
        end else begin
            phase_r <= phase_nxt_s;
            timer_r <= timer_nxt_s;
        end
    end

    // Pedestrian latches: a press on the green-entry edge is held for the following green.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ped_latch_a_r <= 1'b0;
            ped_latch_b_r <= 1'b0;
            walk_act_a_r  <= 1'b0;
            walk_act_b_r  <= 1'b0;
        end else begin
            if (enter_a_s) begin
                walk_act_a_r  <= ped_latch_a_r;
                ped_latch_a_r <= ped_req_a;
            end else begin
                ped_latch_a_r <= ped_latch_a_r | ped_req_a;
                if (leave_a_s) walk_act_a_r <= 1'b0;
                else           walk_act_a_r <= walk_act_a_r;
            end
            if (enter_b_s) begin
                walk_act_b_r  <= ped_latch_b_r;
                ped_latch_b_r <= ped_req_b;
            end else begin
                ped_latch_b_r <= ped_latch_b_r | ped_req_b;
                if (leave_b_s) walk_act_b_r <= 1'b0;
                else           walk_act_b_r <= walk_act_b_r;
            end
        end
    end

    assign a_green  = (phase_r == A_GREEN);
    assign a_yellow = (phase_r == A_YEL);
    assign a_red    = ~(a_green | a_yellow);
    assign b_green  = (phase_r == B_GREEN);
    assign b_yellow = (phase_r == B_YEL);
    assign b_red    = ~(b_green | b_yellow);

    // Walk fits inside minimum green, so it never overlaps yellow.
    assign walk_a = a_green & walk_act_a_r & (timer_r < WALK_T);
    assign walk_b = b_green & walk_act_b_r & (timer_r < WALK_T);

    assign phase = phase_r;
    assign timer = timer_r;

endmodule

// File: tb/tb_tlc_demand_scheduler.sv
// Self-checking bench for tlc_demand_scheduler: a reference model pushes the
// expected outputs per edge into a scoreboard, plus directed timing checks.
module tb_tlc_demand_scheduler;

    localparam int MIN_G  = 10;
    localparam int MAX_G  = 32;
    localparam int YEL    = 4;
    localparam int AR     = 4;
    localparam int WALK_C = 6;

    typedef struct packed {
        logic [2:0] ph;
        logic [5:0] tm;
        logic [5:0] heads;
        logic [1:0] walks;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       veh_req_a, veh_req_b, ped_req_a, ped_req_b;
    logic       a_red, a_yellow, a_green, b_red, b_yellow, b_green;
    logic       walk_a, walk_b;
    logic [2:0] phase;
    logic [5:0] timer;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t sb_q[$];

    int m_ph, m_tm;
    bit m_pla, m_plb, m_wa, m_wb;

    tlc_demand_scheduler dut (
        .clk(clk), .reset(reset),
        .veh_req_a(veh_req_a), .veh_req_b(veh_req_b),
        .ped_req_a(ped_req_a), .ped_req_b(ped_req_b),
        .a_red(a_red), .a_yellow(a_yellow), .a_green(a_green),
        .b_red(b_red), .b_yellow(b_yellow), .b_green(b_green),
        .walk_a(walk_a), .walk_b(walk_b),
        .phase(phase), .timer(timer)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_tm = 0;
        m_pla = 1'b0; m_plb = 1'b0; m_wa = 1'b0; m_wb = 1'b0;
    endtask

    // Advance the reference model by one edge and report its expected outputs.
    task automatic model_step(output exp_t e);
        int np;
        bit da, db;
        da = veh_req_a | m_pla;
        db = veh_req_b | m_plb;
        case (m_ph)
            0: np = (m_tm >= MIN_G-1 && db && (!veh_req_a || m_tm == MAX_G-1)) ? 1 : 0;
            1: np = (m_tm == YEL-1) ? 2 : 1;
            2: np = (m_tm == AR-1) ? 3 : 2;
            3: np = (m_tm >= MIN_G-1 && da && (!veh_req_b || m_tm == MAX_G-1)) ? 4 : 3;
            4: np = (m_tm == YEL-1) ? 5 : 4;
            5: np = (m_tm == AR-1) ? 0 : 5;
            default: np = 2;
        endcase
        if (np == 0 && m_ph != 0) begin
            m_wa = m_pla; m_pla = ped_req_a;
        end else begin
            if (m_ph == 0 && np != 0) m_wa = 1'b0;
            m_pla = m_pla | ped_req_a;
        end
        if (np == 3 && m_ph != 3) begin
            m_wb = m_plb; m_plb = ped_req_b;
        end else begin
            if (m_ph == 3 && np != 3) m_wb = 1'b0;
            m_plb = m_plb | ped_req_b;
        end
        if (np != m_ph) m_tm = 0;
        else if (!((np == 0 || np == 3) && m_tm == MAX_G-1)) m_tm = m_tm + 1;
        m_ph = np;
        e.ph    = 3'(m_ph);
        e.tm    = 6'(m_tm);
        e.heads = {m_ph != 0 && m_ph != 1, m_ph == 1, m_ph == 0,
                   m_ph != 3 && m_ph != 4, m_ph == 4, m_ph == 3};
        e.walks = {m_ph == 0 && m_wa && m_tm < WALK_C, m_ph == 3 && m_wb && m_tm < WALK_C};
    endtask

    // One clock: predict, clock the DUT, compare away from the edge, return at negedge.
    task automatic cycle();
        exp_t e;
        model_step(e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e = sb_q.pop_front();
        check("phase", phase, e.ph);
        check("timer", timer, e.tm);
        check("heads", {a_red, a_yellow, a_green, b_red, b_yellow, b_green}, e.heads);
        check("walks", {walk_a, walk_b}, e.walks);
        @(negedge clk);
    endtask

    task automatic run_to(input int ph, input int limit, input string tag);
        for (int i = 0; i < limit && phase != 3'(ph); i++) cycle();
        check(tag, phase, ph);
    endtask

    task automatic count_walk_a(output int n);
        n = 0;
        for (int i = 0; i < 40 && phase == 3'd0; i++) begin
            if (walk_a) n++;
            cycle();
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        veh_req_a = 1'b0; veh_req_b = 1'b0; ped_req_a = 1'b0; ped_req_b = 1'b0;
        sb_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_phase", phase, 0);
        check("rst_timer", timer, 0);
        check("rst_heads", {a_red, a_yellow, a_green, b_red, b_yellow, b_green}, 6'b001100);
        check("rst_walks", {walk_a, walk_b}, 2'b00);
        reset = 1'b1;
        cyc = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int f1, f2, f3, f4, f0, nw, fw, lw, prev, n;

        // Idle: A rests with the timer saturated.
        do_reset();
        repeat (100) cycle();
        check("idle_phase", phase, 0);
        check("idle_timer", timer, MAX_G-1);

        // Only B vehicle: A leaves at minimum green.
        do_reset();
        veh_req_b = 1'b1;
        f1 = -1; f2 = -1; f3 = -1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (phase == 3'd1 && f1 < 0) f1 = cyc;
            if (phase == 3'd2 && f2 < 0) f2 = cyc;
            if (b_green && f3 < 0) f3 = cyc;
        end
        check("b_only_ayel", f1, 10);
        check("b_only_aallred", f2, 14);
        check("b_only_bgreen", f3, 18);

        // Both vehicles: max-green alternation, period 80.
        do_reset();
        veh_req_a = 1'b1; veh_req_b = 1'b1;
        f1 = -1; f3 = -1; f4 = -1; f0 = -1; prev = 0;
        for (int i = 0; i < 120; i++) begin
            cycle();
            if (phase == 3'd1 && f1 < 0) f1 = cyc;
            if (phase == 3'd3 && f3 < 0) f3 = cyc;
            if (phase == 3'd4 && f4 < 0) f4 = cyc;
            if (phase == 3'd0 && prev == 5 && f0 < 0) f0 = cyc;
            prev = int'(phase);
        end
        check("both_ayel", f1, 32);
        check("both_bgreen", f3, 40);
        check("both_byel", f4, 72);
        check("both_period", f0, 80);

        // Pedestrian B pulse with no vehicles.
        do_reset();
        repeat (3) cycle();
        ped_req_b = 1'b1;
        cycle();
        ped_req_b = 1'b0;
        f3 = -1; nw = 0; fw = -1; lw = -1;
        for (int i = 0; i < 56; i++) begin
            cycle();
            if (phase == 3'd3 && f3 < 0) f3 = cyc;
            if (walk_b) begin
                nw++;
                if (fw < 0) fw = cyc;
                lw = cyc;
            end
        end
        check("pedb_bgreen", f3, 18);
        check("pedb_walk_len", nw, WALK_C);
        check("pedb_walk_first", fw, 18);
        check("pedb_walk_last", lw, 23);
        check("pedb_rest", phase, 3);

        // Press A exactly on the edge that enters A green: served next A green.
        veh_req_a = 1'b1;
        for (int i = 0; i < 40 && phase != 3'd0; i++) begin
            ped_req_a = (phase == 3'd5 && timer == 6'(AR-1));
            cycle();
        end
        ped_req_a = 1'b0;
        check("peda_enter", phase, 0);
        veh_req_a = 1'b0; veh_req_b = 1'b1;
        count_walk_a(n);
        check("peda_walk_now", n, 0);
        run_to(3, 20, "peda_to_b");
        veh_req_b = 1'b0; veh_req_a = 1'b1;
        run_to(0, 40, "peda_back_a");
        veh_req_a = 1'b0; veh_req_b = 1'b1;
        count_walk_a(n);
        check("peda_walk_next", n, WALK_C);

        // Async reset mid B yellow discards a pending A pedestrian request.
        run_to(3, 20, "rst_to_b");
        ped_req_a = 1'b1;
        cycle();
        ped_req_a = 1'b0; veh_req_b = 1'b0;
        run_to(4, 40, "rst_to_byel");
        #2 reset = 1'b0;
        #1;
        check("async_phase", phase, 0);
        check("async_heads", {a_red, a_yellow, a_green, b_red, b_yellow, b_green}, 6'b001100);
        sb_q.delete();
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        cyc = 0;
        veh_req_b = 1'b1;
        run_to(3, 40, "post_rst_b");
        veh_req_b = 1'b0; veh_req_a = 1'b1;
        run_to(0, 40, "post_rst_a");
        veh_req_a = 1'b0; veh_req_b = 1'b1;
        count_walk_a(n);
        check("post_rst_walk", n, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
